// File: rtl/weight_sram_ctrl.sv
// Weight SRAM sequencer: kernel-major bulk load from the host side and
// single-kernel fetch to the convolution datapath.
module weight_sram_ctrl #(
    parameter int IFMAPS  = 16,
    parameter int PIXELS  = 25,
    parameter int DATA_W  = 8,
    parameter int KADDR_W = 4,
    parameter int PADDR_W = 6
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               load_start,
    input  logic               load_valid,
    input  logic [DATA_W-1:0]  load_data,
    output logic               load_ready,
    output logic               load_done,
    input  logic               fetch_start,
    input  logic [KADDR_W-1:0] fetch_kern,
    output logic               w_valid,
    output logic [DATA_W-1:0]  w_data,
    output logic               w_last,
    output logic               busy,
    output logic               sram_CS,
    output logic               sram_WE,
    output logic               sram_RD,
    output logic [KADDR_W-1:0] sram_kernAddr,
    output logic [PADDR_W-1:0] sram_pixAddr,
    output logic [DATA_W-1:0]  sram_dataIn,
    output logic               sram_ifmaps,
    output logic               sram_pixels,
    input  logic [DATA_W-1:0]  sram_dataOut
);

    localparam logic [KADDR_W-1:0] K_LAST = KADDR_W'(IFMAPS - 1);
    localparam logic [PADDR_W-1:0] P_LAST = PADDR_W'(PIXELS - 1);
    localparam logic [KADDR_W:0]   K_NUM  = (KADDR_W + 1)'(IFMAPS);

    typedef enum logic [1:0] {IDLE, LOAD, FETCH, DRAIN} state_t;

    state_t state, nextState;
    logic [KADDR_W-1:0] kCnt, kNext, issueK;
    logic [PADDR_W-1:0] pCnt, pNext, issueP;
    logic doWrite, doRead, rdLast, fetchOk;

    assign fetchOk     = {1'b0, fetch_kern} < K_NUM;
    assign w_data      = sram_dataOut;
    assign sram_ifmaps = 1'b0;
    assign sram_pixels = 1'b0;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
            kCnt  <= '0;
            pCnt  <= '0;
        end else begin
            state <= nextState;
            kCnt  <= kNext;
            pCnt  <= pNext;
        end
    end

    // The first fetch read is issued straight from IDLE, so p counts the next pixel to read.
    always_comb begin
        nextState = state;
        kNext     = kCnt;
        pNext     = pCnt;
        issueK    = kCnt;
        issueP    = pCnt;
        doWrite   = 1'b0;
        doRead    = 1'b0;
        unique case (state)
            IDLE: begin
                if (load_start) begin
                    nextState = LOAD;
                    kNext     = '0;
                    pNext     = '0;
                end else if (fetch_start && fetchOk) begin
                    nextState = FETCH;
                    doRead    = 1'b1;
                    issueK    = fetch_kern;
                    issueP    = '0;
                    kNext     = fetch_kern;
                    pNext     = PADDR_W'(1);
                end
            end
            LOAD: begin
                if (load_valid) begin
                    doWrite = 1'b1;
                    if (pCnt == P_LAST) begin
                        pNext = '0;
                        if (kCnt == K_LAST) begin
                            kNext     = '0;
                            nextState = IDLE;
                        end else begin
                            kNext = kCnt + 1'b1;
                        end
                    end else begin
                        pNext = pCnt + 1'b1;
                    end
                end
            end
            FETCH: begin
                doRead = 1'b1;
                if (pCnt == P_LAST) begin
                    pNext     = '0;
                    nextState = DRAIN;
                end else begin
                    pNext = pCnt + 1'b1;
                end
            end
            DRAIN: begin
                kNext     = '0;
                pNext     = '0;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        load_ready = (state == LOAD);
        busy       = (state != IDLE);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sram_CS       <= 1'b0;
            sram_WE       <= 1'b0;
            sram_RD       <= 1'b0;
            sram_kernAddr <= '0;
            sram_pixAddr  <= '0;
            sram_dataIn   <= '0;
            rdLast        <= 1'b0;
            w_valid       <= 1'b0;
            w_last        <= 1'b0;
            load_done     <= 1'b0;
        end else begin
            sram_CS <= doWrite | doRead;
            sram_WE <= doWrite;
            sram_RD <= doRead;
            if (doWrite | doRead) begin
                sram_kernAddr <= issueK;
                sram_pixAddr  <= issueP;
            end
            if (doWrite) sram_dataIn <= load_data;
            // Flags trail the read by one cycle to line up with sram_dataOut.
            rdLast    <= doRead && (issueP == P_LAST);
            w_valid   <= sram_RD;
            w_last    <= rdLast;
            load_done <= doWrite && (kCnt == K_LAST) && (pCnt == P_LAST);
        end
    end

endmodule

// File: tb/tb_weight_sram_ctrl.sv
// Self-checking bench for weight_sram_ctrl with a behavioural SRAM and
// a kernel/pixel array model of the expected weight contents.
module tb_weight_sram_ctrl;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic       load_start, load_valid, load_ready, load_done;
    logic [7:0] load_data;
    logic       fetch_start;
    logic [3:0] fetch_kern;
    logic       w_valid, w_last, busy;
    logic [7:0] w_data;
    logic       sram_CS, sram_WE, sram_RD, sram_ifmaps, sram_pixels;
    logic [3:0] sram_kernAddr;
    logic [5:0] sram_pixAddr;
    logic [7:0] sram_dataIn, sram_dataOut;

    weight_sram_ctrl dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .load_start(load_start), .load_valid(load_valid),
        .load_data(load_data), .load_ready(load_ready),
        .load_done(load_done), .fetch_start(fetch_start),
        .fetch_kern(fetch_kern), .w_valid(w_valid),
        .w_data(w_data), .w_last(w_last), .busy(busy),
        .sram_CS(sram_CS), .sram_WE(sram_WE), .sram_RD(sram_RD),
        .sram_kernAddr(sram_kernAddr), .sram_pixAddr(sram_pixAddr),
        .sram_dataIn(sram_dataIn), .sram_ifmaps(sram_ifmaps),
        .sram_pixels(sram_pixels), .sram_dataOut(sram_dataOut)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    int wrCount = 0;
    int rdCount = 0;
    int doneCount = 0;

    typedef struct {int k; int p; int d;} wr_t;
    wr_t wq[$];

    logic [7:0] mem    [16][25];
    logic [7:0] refMem [16][25];
    logic [7:0] got    [25];

    // External SRAM: acts on the registered controls at the next edge
    always @(posedge Clk) begin
        if (sram_CS && sram_WE && int'(sram_pixAddr) < 25)
            mem[sram_kernAddr][sram_pixAddr] <= sram_dataIn;
        if (sram_CS && sram_RD && int'(sram_pixAddr) < 25)
            sram_dataOut <= mem[sram_kernAddr][sram_pixAddr];
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge Clk) begin
        if (load_done) doneCount++;
        if (sram_CS && sram_RD) rdCount++;
        if (Rst_n && sram_CS && sram_WE) begin
            wr_t e;
            wrCount++;
            checks++;
            if (wq.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected k=%0d p=%0d", sram_kernAddr, sram_pixAddr);
            end else begin
                e = wq.pop_front();
                if (int'(sram_kernAddr) != e.k || int'(sram_pixAddr) != e.p ||
                    int'(sram_dataIn) != e.d) begin
                    errors++;
                    $display("FAIL wr_beat got k%0d p%0d d%0d expected k%0d p%0d d%0d",
                             sram_kernAddr, sram_pixAddr, sram_dataIn, e.k, e.p, e.d);
                end
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Streams nBeats beats; beat n goes to kernel n/25, pixel n%25.
    task automatic doLoad(input int nBeats, input bit randData, input bit randGap,
                          input bit expectDone);
        int n = 0;
        int cyc = 0;
        int rdBefore;
        bit v;
        logic [7:0] d;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        rdBefore = rdCount;
        chk("load_ready", int'(load_ready), 1);
        chk("load_busy", int'(busy), 1);
        while (n < nBeats && cyc < 4000) begin
            v = randGap ? ($urandom_range(0, 3) != 0) : (cyc % 3 != 2);
            d = randData ? 8'($urandom) : 8'(n);
            load_valid = v;
            load_data  = d;
            if (v) wq.push_back('{n / 25, n % 25, int'(d)});
            tick();
            if (v) begin
                refMem[n / 25][n % 25] = d;
                n++;
            end
            cyc++;
        end
        load_valid = 1'b0;
        if (n < nBeats) chk("load_timeout", n, nBeats);
        chk("load_no_reads", rdCount - rdBefore, 0);
        if (expectDone) begin
            chk("load_done_hi", int'(load_done), 1);
            chk("load_busy_end", int'(busy), 0);
        end
    endtask

    task automatic doFetch(input int kern);
        fetch_start = 1'b1;
        fetch_kern  = 4'(kern);
        tick();
        fetch_start = 1'b0;
        chk("fetch_busy", int'(busy), 1);
        chk("fetch_early_valid", int'(w_valid), 0);
        chk("load_done_pulse", int'(load_done), 0);
        for (int i = 0; i < 25; i++) begin
            tick();
            got[i] = w_data;
            chk($sformatf("w_valid_k%0d_p%0d", kern, i), int'(w_valid), 1);
            chk($sformatf("w_data_k%0d_p%0d", kern, i), int'(w_data),
                int'(refMem[kern][i]));
            chk($sformatf("w_last_k%0d_p%0d", kern, i), int'(w_last), int'(i == 24));
        end
        tick();
        chk("fetch_valid_end", int'(w_valid), 0);
        chk("fetch_busy_end", int'(busy), 0);
    endtask

    typedef struct {
        bit ls; bit fs; logic [3:0] fk;
        bit eBusy; bit eReady; bit eRd; int eKern;
    } vec_t;

    initial begin
        vec_t vecs[5];
        int wrBefore;
        vecs[0] = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 0};
        vecs[1] = '{1'b1, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 0};
        vecs[2] = '{1'b0, 1'b1, 4'd3,  1'b1, 1'b0, 1'b1, 3};
        vecs[3] = '{1'b1, 1'b1, 4'd7,  1'b1, 1'b1, 1'b0, 0};
        vecs[4] = '{1'b0, 1'b1, 4'd15, 1'b1, 1'b0, 1'b1, 15};

        Rst_n = 1'b0;
        load_start = 1'b0; load_valid = 1'b0; load_data = '0;
        fetch_start = 1'b0; fetch_kern = '0;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(load_ready), 0);
        chk("rst_w_valid", int'(w_valid), 0);
        chk("rst_cs", int'(sram_CS), 0);
        chk("rst_we", int'(sram_WE), 0);
        chk("rst_rd", int'(sram_RD), 0);
        chk("rst_done", int'(load_done), 0);
        Rst_n = 1'b1;
        tick();

        // Start decisions from IDLE, each followed by an asynchronous reset
        for (int i = 0; i < 5; i++) begin
            load_start  = vecs[i].ls;
            fetch_start = vecs[i].fs;
            fetch_kern  = vecs[i].fk;
            tick();
            load_start  = 1'b0;
            fetch_start = 1'b0;
            chk($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].eBusy));
            chk($sformatf("vec%0d_ready", i), int'(load_ready), int'(vecs[i].eReady));
            chk($sformatf("vec%0d_rd", i), int'(sram_RD), int'(vecs[i].eRd));
            if (vecs[i].eRd)
                chk($sformatf("vec%0d_kern", i), int'(sram_kernAddr), vecs[i].eKern);
            #2 Rst_n = 1'b0;
            #1;
            chk($sformatf("vec%0d_arst_busy", i), int'(busy), 0);
            chk($sformatf("vec%0d_arst_rd", i), int'(sram_RD), 0);
            chk($sformatf("vec%0d_arst_ready", i), int'(load_ready), 0);
            #1 Rst_n = 1'b1;
            tick();
        end

        // Full load with every third beat dropped, fetch in the load_done cycle
        wrBefore = wrCount;
        doLoad(400, 1'b0, 1'b0, 1'b1);
        doFetch(15);
        chk("b2b_last_byte", int'(got[24]), 8'h8F);
        chk("load_write_count", wrCount - wrBefore, 400);

        doFetch(5);
        chk("k5_first", int'(got[0]), 125);
        chk("k5_last", int'(got[24]), 149);

        // Randomised contents and gaps, random kernels
        wrBefore = wrCount;
        doLoad(400, 1'b1, 1'b1, 1'b1);
        tick();
        chk("load_done_single", int'(load_done), 0);
        chk("rand_write_count", wrCount - wrBefore, 400);
        for (int j = 0; j < 6; j++) doFetch($urandom_range(0, 15));

        // Reset in the middle of a load keeps the words already written
        wrBefore = wrCount;
        doLoad(30, 1'b0, 1'b0, 1'b0);
        tick();
        chk("partial_writes", wrCount - wrBefore, 30);
        #2 Rst_n = 1'b0;
        #1;
        chk("midload_busy", int'(busy), 0);
        chk("midload_ready", int'(load_ready), 0);
        chk("midload_cs", int'(sram_CS), 0);
        #1 Rst_n = 1'b1;
        tick();
        doFetch(1);
        for (int i = 0; i < 5; i++)
            chk($sformatf("partial_k1_p%0d", i), int'(got[i]), 25 + i);

        chk("done_pulses", doneCount, 2);
        chk("wq_drained", wq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
